// File: rtl/spi_master_xfer_if.sv
// Command/SPI bundle for spi_master_xfer.
//   master modport : the SPI master itself (takes commands and miso, drives
//                    status, result and the SPI pins).
//   slave modport  : the peer view (command logic plus attached device).
// Signals: start/ready handshake, data_in, cs_sel, cpol, cpha, lsb_first,
// hold_cs, cs_release, busy, data_out, data_valid, cs_n, sck, mosi, miso.
interface spi_master_xfer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 1
) ();
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic [CSW-1:0]        cs_sel;
  logic                  cpol;
  logic                  cpha;
  logic                  lsb_first;
  logic                  hold_cs;
  logic                  cs_release;
  logic                  miso;
  logic                  ready;
  logic                  busy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [NUM_CS-1:0]     cs_n;
  logic                  sck;
  logic                  mosi;

  modport master (
    input  start, data_in, cs_sel, cpol, cpha, lsb_first, hold_cs, cs_release, miso,
    output ready, busy, data_out, data_valid, cs_n, sck, mosi
  );

  modport slave (
    output start, data_in, cs_sel, cpol, cpha, lsb_first, hold_cs, cs_release, miso,
    input  ready, busy, data_out, data_valid, cs_n, sck, mosi
  );
endinterface

// File: rtl/spi_master_xfer.sv
// Parametrised SPI master: DATA_WIDTH-bit words, runtime CPOL/CPHA and bit
// order, NUM_CS active-low selects, bursts with CS held between words.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus        : spi_master_xfer_if.master (command handshake, result strobe,
//                SPI pins cs_n/sck/mosi/miso)
// SCK half period is CLK_DIVIDER clk cycles. All pin outputs are registered.
module spi_master_xfer #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CS      = 1,
  parameter int CLK_DIVIDER = 2
) (
  input  logic                clk,
  input  logic                reset,
  spi_master_xfer_if.master   bus
);
  localparam int W   = DATA_WIDTH;
  localparam int T   = CLK_DIVIDER;
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int TW  = (T > 1) ? $clog2(T) : 1;
  localparam int EW  = $clog2(2 * W + 1);
  localparam logic [EW-1:0] EDGES = EW'(2 * W);

  typedef enum logic [1:0] {IDLE, XFER, HOLD, RELEASE} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [W-1:0]      tx_q, tx_d;
  logic [W-1:0]      rx_q, rx_d;
  logic [W-1:0]      dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic              hold_q, hold_d;
  logic [NUM_CS-1:0] csn_q, csn_d;

  logic              accept, tmr_last, cpha_new, tx_bit;
  logic [W-1:0]      tx_shift, rx_shift;
  logic [NUM_CS-1:0] csn_sel;

  assign bus.ready = (state_q == IDLE) || (state_q == HOLD && !bus.cs_release);
  assign bus.busy  = (state_q != IDLE);
  assign accept    = bus.start && bus.ready;
  assign tmr_last  = (tmr_q == TW'(T - 1));
  // Mode is only taken from the inputs at the start of a burst.
  assign cpha_new  = (state_q == IDLE) ? bus.cpha : cpha_q;

  assign tx_bit    = lsb_q ? tx_q[0] : tx_q[W-1];
  assign tx_shift  = lsb_q ? {1'b0, tx_q[W-1:1]} : {tx_q[W-2:0], 1'b0};
  // First received bit ends up where the first transmitted bit came from.
  assign rx_shift  = lsb_q ? {bus.miso, rx_q[W-1:1]} : {rx_q[W-2:0], bus.miso};

  always_comb begin
    csn_sel = '1;
    for (int i = 0; i < NUM_CS; i++) csn_sel[i] = (bus.cs_sel != CSW'(i));
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE: begin
        sck_d  = bus.cpol;
        mosi_d = 1'b1;
        csn_d  = '1;
      end
      XFER: begin
        tmr_d = tmr_last ? '0 : tmr_q + 1'b1;
        if (tmr_last) begin
          if (edge_q != EDGES) begin
            sck_d  = ~sck_q;
            edge_d = edge_q + 1'b1;
            if (!edge_q[0]) begin
              // leading edge
              if (cpha_q) begin
                mosi_d = tx_bit;
                tx_d   = tx_shift;
              end else begin
                rx_d = rx_shift;
              end
            end else begin
              // trailing edge; cpha=0 has nothing left to shift after the last bit
              if (cpha_q) begin
                rx_d = rx_shift;
              end else if (edge_q != EDGES - 1'b1) begin
                mosi_d = tx_bit;
                tx_d   = tx_shift;
              end
            end
          end else begin
            // one extra half period after the last edge closes the word
            dout_d = rx_q;
            dv_d   = 1'b1;
            edge_d = '0;
            if (hold_q) begin
              state_d = HOLD;
            end else begin
              state_d = RELEASE;
              csn_d   = '1;
            end
          end
        end
      end
      HOLD: begin
        if (bus.cs_release) begin
          state_d = RELEASE;
          csn_d   = '1;
          tmr_d   = '0;
        end
      end
      RELEASE: begin
        tmr_d = tmr_last ? '0 : tmr_q + 1'b1;
        if (tmr_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = XFER;
      tmr_d   = '0;
      edge_d  = '0;
      rx_d    = '0;
      lsb_d   = bus.lsb_first;
      hold_d  = bus.hold_cs;
      if (state_q == IDLE) begin
        cpha_d = bus.cpha;
        csn_d  = csn_sel;
      end
      if (!cpha_new) begin
        // cpha=0 presents the first bit during setup
        mosi_d = bus.lsb_first ? bus.data_in[0] : bus.data_in[W-1];
        tx_d   = bus.lsb_first ? {1'b0, bus.data_in[W-1:1]} : {bus.data_in[W-2:0], 1'b0};
      end else begin
        tx_d = bus.data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b1;
      csn_q   <= '1;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.data_valid = dv_q;
  assign bus.sck        = sck_q;
  assign bus.mosi       = mosi_q;
  assign bus.cs_n       = csn_q;
endmodule

// File: tb/tb_spi_master_xfer.sv
module tb_spi_master_xfer;
  localparam int W   = 8;
  localparam int T   = 2;
  localparam int NCS = 4;
  localparam int WB  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_master_xfer_if #(.DATA_WIDTH(W),  .NUM_CS(NCS)) busA ();
  spi_master_xfer_if #(.DATA_WIDTH(WB), .NUM_CS(1))   busB ();

  spi_master_xfer #(.DATA_WIDTH(W), .NUM_CS(NCS), .CLK_DIVIDER(T)) dutA (
    .clk(clk), .reset(reset), .bus(busA));
  spi_master_xfer #(.DATA_WIDTH(WB), .NUM_CS(1), .CLK_DIVIDER(1)) dutB (
    .clk(clk), .reset(reset), .bus(busB));

  logic loopA, misoA_drv;
  assign busA.miso = loopA ? busA.mosi : misoA_drv;
  assign busB.miso = busB.mosi;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic           mon_cpol, mon_cpha;
  logic [NCS-1:0] exp_csn;

  // Runs one word on instance A. Call just after a negedge with mode inputs set.
  task automatic run_word(input string tag, input logic [W-1:0] din, input logic lsb,
                          input logic hold, input logic loop, input logic [W-1:0] pat,
                          input logic [W-1:0] exp_mosi, input logic [W-1:0] exp_dout);
    logic sck_prev, lead;
    logic [W-1:0] seq;
    int edges, first_e, last_e, dv_c, cs_bad, nbit, rdy_c;
    check($sformatf("%s ready_before", tag), busA.ready, 1);
    busA.data_in = din; busA.lsb_first = lsb; busA.hold_cs = hold;
    loopA = loop; misoA_drv = 1'b1;
    busA.start = 1'b1;
    sck_prev = busA.sck;
    edges = 0; first_e = 0; last_e = 0; dv_c = 0; cs_bad = 0; nbit = 0; seq = '0;
    @(posedge clk);
    for (int c = 1; c <= 200 && dv_c == 0; c++) begin
      @(negedge clk);
      busA.start = 1'b0;
      if (c == 1 && !loop) misoA_drv = pat[W-1];
      if (busA.sck !== sck_prev) begin
        edges++;
        if (edges == 1) first_e = c;
        last_e = c;
        lead = (sck_prev == mon_cpol);
        if (lead != mon_cpha) seq = {seq[W-2:0], busA.mosi};
        if (!lead && !loop) begin
          nbit++;
          if (nbit < W) misoA_drv = pat[W-1-nbit];
        end
        sck_prev = busA.sck;
      end
      if (busA.data_valid) dv_c = c;
      else if (busA.cs_n !== exp_csn) cs_bad++;
    end
    check($sformatf("%s dv_cycle", tag), dv_c, (2*W+1)*T+1);
    check($sformatf("%s sck_edges", tag), edges, 2*W);
    check($sformatf("%s first_edge", tag), first_e, 1+T);
    check($sformatf("%s last_edge", tag), last_e, 1+2*W*T);
    check($sformatf("%s mosi_bits", tag), seq, exp_mosi);
    check($sformatf("%s data_out", tag), busA.data_out, exp_dout);
    check($sformatf("%s cs_during", tag), cs_bad, 0);
    check($sformatf("%s sck_end", tag), busA.sck, mon_cpol);
    check($sformatf("%s cs_at_end", tag), busA.cs_n, hold ? exp_csn : {NCS{1'b1}});
    if (!hold) begin
      rdy_c = 0; cs_bad = 0;
      for (int c = 1; c <= 20 && rdy_c == 0; c++) begin
        @(negedge clk);
        if (busA.ready) rdy_c = c;
        else if (busA.cs_n !== {NCS{1'b1}} || busA.data_valid) cs_bad++;
      end
      check($sformatf("%s release_len", tag), rdy_c, T);
      check($sformatf("%s release_cs", tag), cs_bad, 0);
    end
  endtask

  typedef struct {
    logic           cpol, cpha, lsb;
    logic [1:0]     sel;
    logic           loop;
    logic [W-1:0]   din, pat, exp_mosi, exp_dout;
    logic [NCS-1:0] csn;
  } vec_t;
  vec_t vec [7];

  initial begin
    logic sck_prev;
    logic [WB-1:0] seqB;
    int edges, dv_cnt, bad;

    vec[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 4'b1110};
    vec[1] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 8'h81, 8'h00, 8'h81, 8'h81, 4'b1101};
    vec[2] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 8'h81, 8'h00, 8'h81, 8'h81, 4'b1101};
    vec[3] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 8'h81, 8'h00, 8'h81, 8'h81, 4'b1011};
    vec[4] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 8'h35, 8'h00, 8'hAC, 8'h35, 4'b1011};
    vec[5] = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 8'hC2, 8'h00, 8'h43, 8'hC2, 4'b1110};
    vec[6] = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 8'h5A, 8'hF0, 8'h5A, 8'hF0, 4'b0111};

    reset = 1'b1;
    busA.start = 0; busA.data_in = '0; busA.cs_sel = '0; busA.cpol = 0; busA.cpha = 0;
    busA.lsb_first = 0; busA.hold_cs = 0; busA.cs_release = 0;
    busB.start = 0; busB.data_in = '0; busB.cs_sel = '0; busB.cpol = 0; busB.cpha = 0;
    busB.lsb_first = 0; busB.hold_cs = 0; busB.cs_release = 0;
    loopA = 1'b1; misoA_drv = 1'b1;
    mon_cpol = 0; mon_cpha = 0; exp_csn = 4'b1110;
    repeat (3) @(negedge clk);

    check("rst cs_n", busA.cs_n, 4'hF);
    check("rst sck", busA.sck, 0);
    check("rst mosi", busA.mosi, 1);
    check("rst data_out", busA.data_out, 0);
    check("rst data_valid", busA.data_valid, 0);
    check("rst busy", busA.busy, 0);
    check("rst ready", busA.ready, 1);
    check("rst B cs_n", busB.cs_n, 1);
    reset = 1'b0;

    // Single words across modes, bit orders and selects
    for (int i = 0; i < 7; i++) begin
      busA.cpol = vec[i].cpol; busA.cpha = vec[i].cpha; busA.cs_sel = vec[i].sel;
      mon_cpol = vec[i].cpol; mon_cpha = vec[i].cpha; exp_csn = vec[i].csn;
      repeat (2) @(negedge clk);
      check($sformatf("v%0d sck_idle", i), busA.sck, vec[i].cpol);
      check($sformatf("v%0d mosi_idle", i), busA.mosi, 1);
      run_word($sformatf("v%0d", i), vec[i].din, vec[i].lsb, 1'b0, vec[i].loop,
               vec[i].pat, vec[i].exp_mosi, vec[i].exp_dout);
    end

    // Burst of three words on CS 2; later words must ignore changed mode/select
    busA.cpol = 0; busA.cpha = 0; busA.cs_sel = 2'd2;
    mon_cpol = 0; mon_cpha = 0; exp_csn = 4'b1011;
    repeat (2) @(negedge clk);
    run_word("b0", 8'h11, 1'b0, 1'b1, 1'b1, 8'h00, 8'h11, 8'h11);
    busA.cs_sel = 2'd0; busA.cpha = 1'b1; busA.cpol = 1'b1;
    run_word("b1", 8'h22, 1'b0, 1'b1, 1'b1, 8'h00, 8'h22, 8'h22);
    run_word("b2", 8'h33, 1'b0, 1'b0, 1'b1, 8'h00, 8'h33, 8'h33);

    // Release and start in the same HOLD cycle: release wins, start not queued
    busA.cpol = 0; busA.cpha = 0; busA.cs_sel = 2'd1;
    mon_cpol = 0; mon_cpha = 0; exp_csn = 4'b1101;
    repeat (2) @(negedge clk);
    run_word("r0", 8'h6C, 1'b0, 1'b1, 1'b1, 8'h00, 8'h6C, 8'h6C);
    busA.cs_release = 1'b1; busA.start = 1'b1; busA.data_in = 8'hFF;
    #1 check("rel ready_in_hold", busA.ready, 0);
    @(negedge clk);
    busA.cs_release = 1'b0;
    check("rel busy", busA.busy, 1);
    check("rel cs_n", busA.cs_n, 4'hF);
    check("rel ready1", busA.ready, 0);
    check("rel no_dv", busA.data_valid, 0);
    @(negedge clk);
    check("rel ready2", busA.ready, 0);
    busA.start = 1'b0;
    @(negedge clk);
    check("rel idle_ready", busA.ready, 1);
    check("rel idle_busy", busA.busy, 0);
    repeat (3) @(negedge clk);
    check("rel not_queued", busA.busy, 0);
    check("rel data_kept", busA.data_out, 8'h6C);

    // Reset at SCK edge 7 (cpol=1 so the sck reset value is visible)
    busA.cpol = 1; busA.cpha = 0; busA.cs_sel = 2'd0;
    repeat (2) @(negedge clk);
    busA.data_in = 8'h96; busA.lsb_first = 0; busA.hold_cs = 0; loopA = 1'b1;
    busA.start = 1'b1;
    sck_prev = busA.sck; edges = 0;
    @(posedge clk);
    for (int c = 1; c <= 100 && edges < 7; c++) begin
      @(negedge clk);
      busA.start = 1'b0;
      if (busA.sck !== sck_prev) begin edges++; sck_prev = busA.sck; end
    end
    check("mrst edge7_reached", edges, 7);
    reset = 1'b1;
    @(negedge clk);
    check("mrst cs_n", busA.cs_n, 4'hF);
    check("mrst sck", busA.sck, 0);
    check("mrst mosi", busA.mosi, 1);
    check("mrst busy", busA.busy, 0);
    check("mrst dv", busA.data_valid, 0);
    reset = 1'b0;
    dv_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busA.data_valid) dv_cnt++;
    end
    check("mrst no_dv_after", dv_cnt, 0);
    busA.cpol = 0; busA.cpha = 0; busA.cs_sel = 2'd0;
    mon_cpol = 0; mon_cpha = 0; exp_csn = 4'b1110;
    repeat (2) @(negedge clk);
    run_word("post_rst", 8'hA5, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5, 8'h3C);

    // W=16, divider 1, lsb-first loopback of 0x0001
    check("B ready", busB.ready, 1);
    busB.data_in = 16'h0001; busB.lsb_first = 1'b1; busB.hold_cs = 1'b0;
    busB.start = 1'b1;
    sck_prev = busB.sck; edges = 0; dv_cnt = 0; bad = 0; seqB = '0;
    @(posedge clk);
    for (int c = 1; c <= 200 && dv_cnt == 0; c++) begin
      @(negedge clk);
      busB.start = 1'b0;
      if (busB.sck !== sck_prev) begin
        edges++;
        if (sck_prev == 1'b0) seqB = {seqB[WB-2:0], busB.mosi};
        sck_prev = busB.sck;
      end
      if (busB.data_valid) dv_cnt = c;
      else if (busB.cs_n !== 1'b0) bad++;
    end
    check("B dv_cycle", dv_cnt, (2*WB+1)*1+1);
    check("B sck_edges", edges, 2*WB);
    check("B mosi_bits", seqB, 16'h8000);
    check("B data_out", busB.data_out, 16'h0001);
    check("B cs_during", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
